inv_mix_columns_iter: RTL and testbench
=======================================

// Module: inv_mix_columns_iter
// PURPOSE
//  AES InvMixColumns step for the decryption datapath: the inverse of the encrypt-side MixColumns.
//  Sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.
//  Iterative: processes COLS_PER_CYCLE 32-bit columns per clock.
//  Uses a valid/ready handshake on both input and output.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4; NCYC = 4/COLS_PER_CYCLE
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    synchronous reset, active-low (rst==0 resets on the next clk edge)
//  in_valid   in   1    data_in holds a state block to transform
//  in_ready   out  1    block accepts input this cycle
//  data_in    in   128  state; byte k = data_in[127-8k -: 8]; column c = bytes 4c..4c+3
//  out_valid  out  1    data_out holds a completed result
//  out_ready  in   1    downstream consumes data_out this cycle
//  data_out   out  128  transformed state, same byte order as data_in
//  busy       out  1    1 while in COMPUTE
// BEHAVIOUR
//  Reset (rst==0 at an edge) produces state=IDLE, col=0, out_valid=0, busy=0, data_out=0, input reg=0.
//  Reset mid-COMPUTE or mid-DONE discards the block; no output is produced for it.
//  Input handshake: accept when in_valid&&in_ready at an edge; data_in is captured into an internal reg.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational on out_ready; no other comb paths.
//  FSM:
//   IDLE    -> COMPUTE on accept, col=0.
//   COMPUTE -> each edge writes columns col..col+COLS_PER_CYCLE-1 of data_out and advances col.
//              Moves to DONE after the edge that writes column 3; in_valid is ignored here.
//   DONE    -> out_valid=1; data_out is held stable until out_ready==1.
//              On out_ready without accept, goes to IDLE.
//              On out_ready with in_valid (simultaneous), accepts the new block and goes straight to COMPUTE, col=0.
//  Latency: accept at edge E0 gives out_valid high after edge E0+NCYC (4, 2 or 1 cycles).
//   Throughput is one block per NCYC+1 cycles.
//  out_valid deasserts on the edge where out_ready==1 while out_valid==1.
//  data_out is meaningful only while out_valid=1; columns may change during COMPUTE.
//  Column math for column bytes a0..a3 (GF(2^8), poly 0x11b, xtime(x) = x<<1 ^ (x[7]?8'h1b:0)):
//   b0 = 0e*a0 ^ 0b*a1 ^ 0d*a2 ^ 09*a3
//   b1 = 09*a0 ^ 0e*a1 ^ 0b*a2 ^ 0d*a3
//   b2 = 0d*a0 ^ 09*a1 ^ 0e*a2 ^ 0b*a3
//   b3 = 0b*a0 ^ 0d*a1 ^ 09*a2 ^ 0e*a3
//  Products are built from x2=xtime(a), x4=xtime(x2), x8=xtime(x4), all 8-bit with no carry out:
//   09=x8^a, 0b=x8^x2^a, 0d=x8^x4^a, 0e=x8^x4^x2.
//  Reduction must test the MSB of each operand byte itself, never byte 0.
//  Pure function of the input: every output byte depends only on its own column.
// TESTING
//  1 Column 8e 4d a1 bc (col0), others 0 -> col0 = db 13 53 45, cols1-3 = 00.
//    out_valid high exactly 4 edges after accept (COLS_PER_CYCLE=1).
//  2 Full block of columns 8e4da1bc, 9fdc589d, 01010101, c6c6c6c6
//    -> db135345, f20a225c, 01010101, c6c6c6c6; repeat for COLS_PER_CYCLE=2 and 4, latency 2 and 1.
//  3 Column d5 d5 d7 d6 -> d4 d4 d4 d5.
//    Hold out_ready=0 for 10 cycles: data_out stable, out_valid=1, in_ready=0.
//  4 Back-to-back: in_valid held high with out_ready=1 -> second block accepted on the DONE edge.
//    Blocks are spaced 5 cycles apart and both results are correct.
//  5 Drive rst=0 for 1 cycle at col=2 -> out_valid stays 0 and data_out=0.
//    The next block completes correctly with full latency.
//  6 Random 1000 blocks: compare against a MixColumns reference model.
//    inv(mix(x))==x for each block; in_valid during COMPUTE is never accepted.

Source files
------------

// File: rtl/inv_mix_columns_iter.sv
// AES InvMixColumns, iterative over the four state columns.
// Valid/ready on both sides; COLS_PER_CYCLE columns per clock.
module inv_mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] res_q, res_d;
  logic [2:0]   col_end;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  assign in_ready  = (state_q == IDLE) |
                     ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == COMPUTE);
  assign data_out  = res_q;
  assign accept    = in_valid & in_ready;
  assign col_end   = {1'b0, col_q} + 3'(COLS_PER_CYCLE);

  // Next-state: capture on accept, transform a slice of columns per cycle
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    blk_d   = blk_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          blk_d   = data_in;
          col_d   = 2'd0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int c = 0; c < 4; c++) begin
          if (3'(c) >= {1'b0, col_q} && 3'(c) < col_end)
            res_d[127-32*c -: 32] = inv_col(blk_q[127-32*c -: 32]);
        end
        col_d = col_end[1:0];
        if (col_end == 3'd4)
          state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            blk_d   = data_in;
            col_d   = 2'd0;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      blk_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter at 1, 2 and 4 columns per cycle.
// Table vectors, handshake corner sequences and a GF(2^8) reference.
module tb_inv_mix_columns_iter;

  logic         clk;
  logic         rst;
  logic [2:0]   iv, ir, ov, orr, bsy;
  logic [127:0] din  [3];
  logic [127:0] dout [3];

  int n_cmp;
  int n_fail;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << k)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[k]),
      .in_ready (ir[k]),
      .data_in  (din[k]),
      .out_valid(ov[k]),
      .out_ready(orr[k]),
      .data_out (dout[k]),
      .busy     (bsy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] x;
    logic [127:0] y;
  } vec_t;

  vec_t tbl [3];

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product on each column; m is the first matrix row
  function automatic logic [127:0] mat_blk(input logic [127:0] s,
                                           input logic [31:0] m);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   co [4];
    logic [7:0]   acc;
    for (int j = 0; j < 4; j++) co[j] = m[31-8*j -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(co[(j - i) & 3], a[j]);
        r[127-8*(4*c+i) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    return mat_blk(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s);
    return mat_blk(s, 32'h02030101);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One block through instance k; noise drives junk on in_valid
  // while computing, which must never be taken.
  task automatic run_block(input int k, input logic [127:0] x,
                           input logic [127:0] y, input bit noise,
                           input string nm);
    int lat;
    @(negedge clk);
    iv[k]  = 1'b1;
    din[k] = x;
    orr[k] = 1'b0;
    #1;
    chk({nm, " in_ready idle"}, 128'(ir[k]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    iv[k] = noise;
    lat = 0;
    while (!ov[k] && lat < 20) begin
      if (noise) begin
        din[k] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        if (ir[k] !== 1'b0 || bsy[k] !== 1'b1) begin
          chk({nm, " busy/in_ready"}, {ir[k], bsy[k]}, 128'b01);
        end
      end
      @(negedge clk);
      lat++;
    end
    iv[k] = 1'b0;
    chk({nm, " latency"}, 128'(lat), 128'(4 >> k));
    chk({nm, " data"}, dout[k], y);
    orr[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    orr[k] = 1'b0;
    chk({nm, " out_valid drop"}, 128'(ov[k]), 128'd0);
  endtask

  logic [127:0] held;
  logic [127:0] xa, xb;
  int           gap;
  logic [127:0] x, y;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    iv     = '0;
    orr    = '0;
    for (int k = 0; k < 3; k++) din[k] = '0;

    tbl[0] = '{128'h8e4da1bc_00000000_00000000_00000000,
               128'hdb135345_00000000_00000000_00000000};
    tbl[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
               128'hdb135345_f20a225c_01010101_c6c6c6c6};
    tbl[2] = '{128'hd5d5d7d6_00000000_00000000_00000000,
               128'hd4d4d4d5_00000000_00000000_00000000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset out_valid %0d", k), 128'(ov[k]), 128'd0);
      chk($sformatf("reset busy %0d", k), 128'(bsy[k]), 128'd0);
      chk($sformatf("reset data_out %0d", k), dout[k], 128'd0);
      chk($sformatf("reset in_ready %0d", k), 128'(ir[k]), 128'd1);
    end

    for (int k = 0; k < 3; k++)
      for (int v = 0; v < 3; v++)
        run_block(k, tbl[v].x, tbl[v].y, 1'b0,
                  $sformatf("tbl k%0d v%0d", k, v));

    // Stall: result held while downstream is not ready
    @(negedge clk);
    iv[0]  = 1'b1;
    din[0] = tbl[2].x;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall first valid", 128'(ov[0]), 128'd1);
    held = dout[0];
    chk("stall data", held, tbl[2].y);
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1;
      #1;
      chk($sformatf("stall hold %0d", i),
          {dout[0], ov[0], ir[0]}, {held, 1'b1, 1'b0});
      iv[0] = 1'b0;
      @(negedge clk);
    end
    orr[0] = 1'b1;
    @(negedge clk);
    orr[0] = 1'b0;

    // Back-to-back: second block taken on the DONE edge
    xa = tbl[1].x;
    xb = 128'h3c1f5a7e_00ff10ee_d5d5d7d6_8e4da1bc;
    iv[0]  = 1'b1;
    din[0] = xa;
    orr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    din[0] = xb;
    gap = 1;
    while (!ov[0] && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b first data", dout[0], ref_inv(xa));
    @(negedge clk);
    iv[0] = 1'b0;
    chk("b2b accept on done", {ov[0], bsy[0]}, 128'b01);
    gap = 1;
    while (!ov[0] && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b spacing", 128'(gap), 128'd5);
    chk("b2b second data", dout[0], ref_inv(xb));
    @(negedge clk);
    orr[0] = 1'b0;
    chk("b2b drained", 128'(ov[0]), 128'd0);

    // Reset at col=2 discards the block
    iv[0]  = 1'b1;
    din[0] = tbl[1].x;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst mid ov/busy %0d", i),
          {ov[0], bsy[0]}, 128'b00);
      @(negedge clk);
    end
    chk("rst mid data_out", dout[0], 128'd0);
    run_block(0, tbl[1].x, tbl[1].y, 1'b0, "after rst");

    // Random blocks against the GF(2^8) model
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      if (i[0]) begin
        y = x;
        x = ref_mix(x);
      end else begin
        y = ref_inv(x);
      end
      run_block(i % 3, x, y, 1'b1, $sformatf("rnd %0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
